// File: rtl/sram_blk_alloc.sv
// Free-block address manager: circular free list that is seeded with every block
// address after reset, grants one address per request and takes back released ones.
// Optional double-free / out-of-range release checking is enabled by defining DOUBLE_FREE_CHK_EN.
`ifndef BLK_ADDR_WIDTH
`define BLK_ADDR_WIDTH 3
`endif

module sram_blk_alloc #(
  parameter int ADDR_WIDTH = `BLK_ADDR_WIDTH,
  parameter int BLK_NUM    = 1 << ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alloc_req,
  output logic                  o_alloc_rdy,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic                  o_sram_addr_vld,
  input  logic [ADDR_WIDTH-1:0] i_free_addr,
  input  logic                  i_free_vld,
  output logic [ADDR_WIDTH:0]   o_free_cnt,
  output logic                  o_init_done,
  output logic                  o_free_err
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(BLK_NUM - 1);
  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH + 1)'(BLK_NUM);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  vld_q;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] list_mem [BLK_NUM];

  logic                  grant;
  logic                  push;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wdata;
  logic                  free_ok;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

`ifdef DOUBLE_FREE_CHK_EN
  logic [BLK_NUM-1:0] alloc_map_q, alloc_map_d, alloc_map_eff;

  // The popped address only appears after the registered list read, so its bit is
  // merged in one cycle late; alloc_map_eff covers the cycle the strobe is high.
  always_comb begin
    alloc_map_eff = alloc_map_q;
    if (vld_q) alloc_map_eff[addr_q] = 1'b1;
  end

  assign free_ok = ({1'b0, i_free_addr} < FULL_CNT) && alloc_map_eff[i_free_addr];

  always_comb begin
    alloc_map_d = alloc_map_eff;
    if (push) alloc_map_d[i_free_addr] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) alloc_map_q <= '0;
    else       alloc_map_q <= alloc_map_d;
  end
`else
  assign free_ok = 1'b1;
`endif

  // During INIT the write pointer doubles as the init counter; it wraps back to 0
  // exactly when the list is full, which is the RUN starting point.
  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    grant     = 1'b0;
    push      = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = i_free_addr;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_wdata = wr_ptr_q;
        wr_ptr_d  = ptr_inc(wr_ptr_q);
        cnt_d     = cnt_q + 1'b1;
        if (wr_ptr_q == LAST_IDX) state_d = S_RUN;
        if (i_free_vld) err_d = 1'b1;
      end
      S_RUN: begin
        grant  = i_alloc_req && (cnt_q != '0);
        push   = i_free_vld && (cnt_q != FULL_CNT) && free_ok;
        mem_we = push;
        if (i_free_vld && !push) err_d = 1'b1;
        if (grant) rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push)  wr_ptr_d = ptr_inc(wr_ptr_q);
        case ({grant, push})
          2'b10:   cnt_d = cnt_q - 1'b1;
          2'b01:   cnt_d = cnt_q + 1'b1;
          default: cnt_d = cnt_q;
        endcase
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_INIT;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      vld_q    <= grant;
      if (grant) addr_q <= list_mem[rd_ptr_q];
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) list_mem[wr_ptr_q] <= mem_wdata;
  end

  assign o_alloc_rdy     = (state_q == S_RUN) && (cnt_q != '0);
  assign o_init_done     = (state_q == S_RUN);
  assign o_sram_addr     = addr_q;
  assign o_sram_addr_vld = vld_q;
  assign o_free_cnt      = cnt_q;
  assign o_free_err      = err_q;

endmodule
